// File: rtl/fft_sched_pkg.sv
// rtl/fft_sched_pkg.sv - shared types and width helpers for the FFT frame scheduler
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } sched_state_t;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    // One extra address bit selects the ping-pong bank.
    function automatic int ram_addr_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// rtl/fft_frame_scheduler_if.sv - sample, FFT stream, result and status signals of the scheduler
interface fft_frame_scheduler_if #(
    parameter int W        = 16,
    parameter int NSamples = 1024
) ();
    import fft_sched_pkg::*;

    localparam int BW = idx_width(NSamples);

    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  fft_data;
    logic          fft_valid;
    logic          fft_ready;
    logic          fft_last;
    logic [BW-1:0] res_data;
    logic          res_valid;
    logic [BW-1:0] pitch_data;
    logic          pitch_valid;
    logic          overrun;
    logic          busy;

    modport slave (
        input  in_data, in_valid, fft_ready, res_data, res_valid,
        output in_ready, fft_data, fft_valid, fft_last, pitch_data, pitch_valid, overrun, busy
    );

    modport master (
        output in_data, in_valid, fft_ready, res_data, res_valid,
        input  in_ready, fft_data, fft_valid, fft_last, pitch_data, pitch_valid, overrun, busy
    );

endinterface

// File: rtl/fft_frame_scheduler_ram.sv
// rtl/fft_frame_scheduler_ram.sv - simple dual-port frame RAM with enabled synchronous read
module frame_pingpong_ram #(
    parameter int W  = 16,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [2**AW];
    logic [W-1:0] r_rdata;

    // Read data holds while i_re is low; the scheduler uses it as a prefetch slot.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - ping-pong frame buffer, FFT frame streamer and pitch result publisher
// Optional WAIT_RES watchdog with timeout port enabled by FFT_SCHED_TIMEOUT_EN.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int W        = 16,
    parameter int NSamples = 1024,
    parameter int TIMEOUT  = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fft_frame_scheduler_if.slave bus
`ifdef FFT_SCHED_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);
    localparam int AW  = idx_width(NSamples);
    localparam int RAW = ram_addr_width(NSamples);
    localparam logic [AW-1:0] LAST_IDX = AW'(NSamples - 1);

    if (NSamples < 4 || (NSamples & (NSamples - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("fft_frame_scheduler: NSamples must be a power of two >= 4 and TIMEOUT >= 1");
    end

    sched_state_t   r_state;
    sched_state_t   w_state_next;
    logic [1:0]     r_full;
    logic [1:0]     w_full_next;
    logic           r_wr_bank;
    logic [AW-1:0]  r_wr_idx;
    logic           r_overrun;
    logic           r_rd_bank;
    logic [AW:0]    r_rd_cnt;
    logic           r_pend;
    logic           r_pend_last;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_out_last;
    logic [AW-1:0]  r_pitch_data;
    logic           r_pitch_valid;

    logic           w_accept;
    logic           w_clr;
    logic           w_load;
    logic           w_wr_ok;
    logic           w_we;
    logic           w_drop;
    logic           w_wr_wrap;
    logic           w_sel_bank;
    logic           w_start;
    logic           w_res_take;
    logic           w_issue_stream;
    logic           w_issue_last;
    logic           w_re;
    logic [RAW-1:0] w_raddr;
    logic [RAW-1:0] w_waddr;
    logic [W-1:0]   w_ram_q;

    assign w_accept  = r_out_valid && bus.fft_ready;
    assign w_clr     = (r_state == STREAM) && w_accept && r_out_last;
    assign w_load    = r_pend && (!r_out_valid || bus.fft_ready);

    // A bank being released this very cycle can already take the next sample.
    assign w_wr_ok   = !r_full[r_wr_bank] || (w_clr && (r_rd_bank == r_wr_bank));
    assign w_we      = bus.in_valid && w_wr_ok;
    assign w_drop    = bus.in_valid && !w_wr_ok;
    assign w_wr_wrap = w_we && (r_wr_idx == LAST_IDX);

    // With both banks full the write pointer sits on the older one.
    assign w_sel_bank = (r_full == 2'b11) ? r_wr_bank : r_full[1];

    assign w_issue_stream = (r_state == STREAM) && !r_rd_cnt[AW] && (!r_pend || w_load);
    assign w_issue_last   = w_issue_stream && (r_rd_cnt[AW-1:0] == LAST_IDX);
    assign w_re           = w_start || w_issue_stream;
    assign w_raddr        = w_start ? {w_sel_bank, {AW{1'b0}}} : {r_rd_bank, r_rd_cnt[AW-1:0]};
    assign w_waddr        = {r_wr_bank, r_wr_idx};

    always_comb begin
        w_full_next = r_full;
        if (w_clr) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_wr_wrap) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

`ifdef FFT_SCHED_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_timeout;
    logic        w_to_fire;
`endif

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_res_take   = 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
        w_to_fire    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (|r_full) begin
                    w_state_next = STREAM;
                    w_start      = 1'b1;
                end
            end
            STREAM: begin
                if (w_clr) begin
                    w_state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (bus.res_valid) begin
                    w_state_next = IDLE;
                    w_res_take   = 1'b1;
                end
`ifdef FFT_SCHED_TIMEOUT_EN
                else if (r_to_cnt == 32'(TIMEOUT - 1)) begin
                    w_state_next = IDLE;
                    w_to_fire    = 1'b1;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_full        <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_wr_idx      <= '0;
            r_overrun     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_rd_cnt      <= '0;
            r_pend        <= 1'b0;
            r_pend_last   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_pitch_data  <= '0;
            r_pitch_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_full  <= w_full_next;
            if (w_we) begin
                r_wr_idx <= r_wr_idx + AW'(1);
                if (w_wr_wrap) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            if (w_start) begin
                r_rd_bank <= w_sel_bank;
                r_rd_cnt  <= (AW+1)'(1);
            end else if (w_issue_stream) begin
                r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
            end
            if (w_re) begin
                r_pend      <= 1'b1;
                r_pend_last <= w_issue_last;
            end else if (w_load) begin
                r_pend <= 1'b0;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ram_q;
                r_out_last  <= r_pend_last;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            r_pitch_valid <= w_res_take;
            if (w_res_take) begin
                r_pitch_data <= bus.res_data;
            end
        end
    end

`ifdef FFT_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (r_state != WAIT_RES) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end
        end
    end

    assign timeout = r_timeout;
`endif

    frame_pingpong_ram #(
        .W  (W),
        .AW (RAW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.in_data),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    assign bus.in_ready    = 1'b1;
    assign bus.fft_valid   = r_out_valid;
    assign bus.fft_data    = r_out_data;
    assign bus.fft_last    = r_out_last;
    assign bus.pitch_data  = r_pitch_data;
    assign bus.pitch_valid = r_pitch_valid;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - directed scoreboard bench for fft_frame_scheduler
module tb_fft_frame_scheduler;

    localparam int TB_TIMEOUT = 100;

    logic clk;
    logic reset_n;
`ifdef FFT_SCHED_TIMEOUT_EN
    logic timeout;
`endif

    fft_frame_scheduler_if #(.W(16), .NSamples(1024)) bus ();

    fft_frame_scheduler #(
        .W        (16),
        .NSamples (1024),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FFT_SCHED_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          acc_cnt = 0;
    int          pv_cnt = 0;
    int          t_last_acc = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [16:0] q_exp[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.fft_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.fft_ready = 1'b0;
                1:       bus.fft_ready = 1'b1;
                default: bus.fft_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every accepted FFT beat pops the oldest expected sample.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(bus.fft_valid), 32'd1);
                check("stall_data_stable", 32'(bus.fft_data), 32'(prev_data));
            end
            if (bus.fft_valid && bus.fft_ready) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_fft_beat", 32'(bus.fft_valid), 32'd0);
                end else begin
                    check("fft_data", 32'(bus.fft_data), 32'(q_exp[0][15:0]));
                    check("fft_last", 32'(bus.fft_last), 32'(q_exp[0][16]));
                    if (q_exp[0][16]) t_last_acc <= cyc + 1;
                    void'(q_exp.pop_front());
                    acc_cnt <= acc_cnt + 1;
                end
            end
            prev_stall <= bus.fft_valid && !bus.fft_ready;
            prev_data  <= bus.fft_data;
            if (bus.pitch_valid) pv_cnt <= pv_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input bit push, input bit last);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        if (push) q_exp.push_back({last, d});
        step();
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (q_exp.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(tag, 32'(q_exp.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_fft_valid", 32'(bus.fft_valid), 32'd0);
        check("rst_fft_data", 32'(bus.fft_data), 32'd0);
        check("rst_fft_last", 32'(bus.fft_last), 32'd0);
        check("rst_pitch_data", 32'(bus.pitch_data), 32'd0);
        check("rst_pitch_valid", 32'(bus.pitch_valid), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef FFT_SCHED_TIMEOUT_EN
        check("rst_timeout", 32'(timeout), 32'd0);
`endif
    endtask

    task automatic publish(input logic [9:0] v);
        int base;
        @(posedge clk);
        #1;
        bus.res_data  = v;
        bus.res_valid = 1'b1;
        @(negedge clk);
        check("busy_in_wait_res", 32'(bus.busy), 32'd1);
        check("pitch_not_early", 32'(bus.pitch_valid), 32'd0);
        base = pv_cnt;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        @(negedge clk);
        check("pitch_valid_pulse", 32'(bus.pitch_valid), 32'd1);
        check("pitch_data", 32'(bus.pitch_data), 32'(v));
        check("busy_back_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("pitch_valid_drops", 32'(bus.pitch_valid), 32'd0);
        check("pitch_pulse_count", 32'(pv_cnt - base), 32'd1);
    endtask

    initial begin
        int lat;
        int c_first;
        int n;
        int acc_base;
        reset_n       = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.res_data  = '0;
        bus.res_valid = 1'b0;

        repeat (20) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        step();
        reset_n = 1'b1;

        // Full-rate frame, data = index.
        rdy_mode = 1;
        step();
        for (int i = 0; i < 1024; i++) send(16'(i), 1'b1, i == 1023);
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.fft_valid && lat < 8);
        c_first = cyc;
        check("first_valid_latency_le3", 32'(lat <= 3), 32'd1);
        check("busy_rises", 32'(bus.busy), 32'd1);
        wait_drain(3000, "drain_full_rate");
        check("full_rate_span", 32'(t_last_acc - c_first), 32'd1024);
        publish(10'd345);

        // Result strobe outside WAIT_RES must be ignored.
        step();
        bus.res_data  = 10'd99;
        bus.res_valid = 1'b1;
        step();
        bus.res_valid = 1'b0;
        @(negedge clk);
        check("ignored_res_pitch_data", 32'(bus.pitch_data), 32'd345);
        check("ignored_res_no_pulse", 32'(bus.pitch_valid), 32'd0);

        // Random 50% back-pressure with random data.
        rdy_mode = 2;
        step();
        for (int i = 0; i < 1024; i++) send(16'($urandom), 1'b1, i == 1023);
        bus.in_valid = 1'b0;
        wait_drain(20000, "drain_random_stall");
        publish(10'd222);

        // Blocked FFT: two frames fill, five extra samples are dropped.
        rdy_mode = 0;
        step();
        step();
        for (int i = 0; i < 2053; i++) begin
            if (i == 2048) begin
                @(negedge clk);
                check("overrun_before_drop", 32'(bus.overrun), 32'd0);
            end
            send(16'(i), i < 2048, (i % 1024) == 1023);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        check("stalled_head_valid", 32'(bus.fft_valid), 32'd1);
        check("stalled_head_data", 32'(bus.fft_data), 32'd0);
        rdy_mode = 1;
        n = 0;
        while (q_exp.size() > 1024 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("bank0_drained", 32'(q_exp.size()), 32'd1024);
        check("hold_in_wait_res", 32'(bus.fft_valid), 32'd0);
        publish(10'd77);
        wait_drain(3000, "drain_bank1");
        check("overrun_sticky", 32'(bus.overrun), 32'd1);
        publish(10'd500);

        // Reset in the middle of a stream.
        acc_base = acc_cnt;
        for (int i = 0; i < 1024; i++) send(16'h4000 + 16'(i), 1'b1, i == 1023);
        bus.in_valid = 1'b0;
        n = 0;
        while ((acc_cnt - acc_base) < 500 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("reached_sample_500", 32'((acc_cnt - acc_base) >= 500), 32'd1);
        step();
        reset_n = 1'b0;
        q_exp.delete();
        @(negedge clk);
        check_reset_outputs();
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 1024; i++) send(16'h8000 + 16'(i), 1'b1, i == 1023);
        bus.in_valid = 1'b0;
        wait_drain(3000, "drain_after_reset");
        publish(10'd3);

`ifdef FFT_SCHED_TIMEOUT_EN
        for (int i = 0; i < 1024; i++) send(16'hC000 + 16'(i), 1'b1, i == 1023);
        bus.in_valid = 1'b0;
        wait_drain(3000, "drain_timeout_frame");
        n = 0;
        @(negedge clk);
        while (!timeout && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_delay", 32'(cyc - t_last_acc), 32'(TB_TIMEOUT));
        check("timeout_pitch_kept", 32'(bus.pitch_data), 32'd3);
        check("timeout_busy_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("timeout_one_cycle", 32'(timeout), 32'd0);
`endif

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Sequences the FFT pitch-detect datapath.
- Buffers incoming audio samples into ping-pong frames of NSamples and streams each complete frame into the FFT core.
- Waits for the FFT's pitch-bin result, then publishes it to the display path.
- Sits between mic_load's sample stream (already in the clk domain) and the FFT/pitch core; single clk domain.

Parameters:
- W, 16: audio sample width in bits.
- NSamples, 1024: frame length in samples; power of two, minimum 4.
- TIMEOUT, 65535: WAIT_RES watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  W  audio sample (dstream .data).
- in_valid  in  1  sample-present strobe (dstream .valid).
- in_ready  out  1  always 1; overflow is handled by dropping samples.
- fft_data  out  W  sample to the FFT.
- fft_valid  out  1  fft_data valid.
- fft_ready  in  1  FFT accepts a sample.
- fft_last  out  1  high with the final sample of a frame.
- res_data  in  $clog2(NSamples)  pitch bin from the FFT.
- res_valid  in  1  one-cycle result strobe.
- pitch_data  out  $clog2(NSamples)  last published pitch bin.
- pitch_valid  out  1  one-cycle pulse when pitch_data updates.
- overrun  out  1  sticky; set when a sample is dropped.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: every output is 0 except in_ready = 1. Both banks are empty, the write bank is 0, the write index is 0 and the state is IDLE. Assertion mid-frame discards all buffered data and any in-flight stream.
- Storage: 2 × NSamples × W RAM with synchronous read (1-cycle latency).
- Write side, per in_valid:
  - Store the sample at the write index of the write bank and increment the index.
  - When the index wraps from NSamples-1 to 0, mark the write bank full and toggle the write bank.
  - If the target bank is still full (its read has not finished): drop the sample, set overrun, and leave the index unchanged.
- FSM:
  - IDLE: when any bank is full (oldest first; bank 0 wins a tie after reset), go to STREAM with read bank = that bank and read index = 0.
  - STREAM:
    - Present samples 0..NSamples-1 in order.
    - fft_valid is held high and fft_data is held stable until fft_ready is sampled high.
    - The stream may stall at any cycle without loss or duplication.
    - A one-entry output register plus RAM prefetch sustains 1 sample/cycle when fft_ready is held high.
    - fft_last = 1 only on index NSamples-1.
    - On the accepted last sample: clear the read bank's full flag in that same cycle and go to WAIT_RES.
  - WAIT_RES:
    - On res_valid: register res_data into pitch_data, pulse pitch_valid the next cycle, go to IDLE.
    - res_valid in any state other than WAIT_RES is ignored.
- Simultaneous events:
  - The write completing bank B in the same cycle the read frees bank B is legal: the new full flag wins.
  - A sample write during the clearing cycle of the bank it targets is accepted (not dropped).
- Latency:
  - From the in_valid that completes a bank, with the FSM in IDLE, to the first fft_valid is 3 cycles or fewer.
  - From res_valid to pitch_valid is 1 cycle.

Optional Feature:
- Macro: FFT_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RES.
  - If TIMEOUT cycles elapse without res_valid: return to IDLE, leave pitch_data unchanged, and pulse an extra output port timeout (1 bit, reset 0) for one cycle.
  - The counter clears on every entry to WAIT_RES.
- Undefined: the timeout port does not exist, and WAIT_RES waits indefinitely.

Decomposition:
- Package fft_sched_pkg:
  - typedef sched_state_t enum {IDLE, STREAM, WAIT_RES}.
  - Localparam function for address widths: $clog2(NSamples) and +1 for the bank bit.
- One sub-module, frame_pingpong_ram: simple dual-port RAM, one write port and one synchronous read port, inferred as block RAM.
- The FSM and handshake logic remain in the top.

Test Plan:
- Reset 20 cycles, then 1024 in_valid with data = index and fft_ready = 1:
  - fft_data streams 0..1023 on consecutive cycles.
  - fft_last is asserted only with 1023.
  - busy rises.
- Same stream with fft_ready toggled pseudo-randomly at 50%: the accepted sequence is exactly 0..1023, with no gaps or duplicates and stable data while stalled.
- After the stream, drive res_data = 10'd345 with res_valid for one cycle:
  - pitch_data = 345 one cycle later, with a single pitch_valid pulse.
  - FSM returns to IDLE (busy = 0).
- Hold fft_ready = 0 while sending 2048 + 5 samples:
  - overrun = 1.
  - Samples 2048..2052 are dropped.
  - Releasing fft_ready streams bank 0 (0..1023), then bank 1 (1024..2047).
- Assert reset_n low mid-STREAM at sample 500:
  - All outputs return to reset values.
  - The next 1024 samples produce a fresh frame starting at sample 0.
- With FFT_SCHED_TIMEOUT_EN defined and TIMEOUT = 100, withhold res_valid:
  - timeout pulses exactly 100 cycles after WAIT_RES entry.
  - pitch_data is unchanged.
  - FSM returns to IDLE.
